// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin N:1 arbitrating mux with a 1-entry output register
// Optional packet lock when RR_ARB_MUX_LOCK_EN is defined.
module rr_arb_mux #(
  parameter int nReq  = 4,
  parameter int DataW = 32,
  parameter int IdW   = $clog2(nReq)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [nReq-1:0]       in_valid,
  output logic [nReq-1:0]       in_ready,
  input  logic [nReq*DataW-1:0] in_data,
  input  logic [nReq-1:0]       in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DataW-1:0]      out_data,
  output logic [IdW-1:0]        out_id,
  output logic                  out_last
);

  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [IdW-1:0]   out_id_q, out_id_d;
  logic             out_last_q, out_last_d;
  logic [nReq-1:0]  mask_q, mask_d;
`ifdef RR_ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [IdW-1:0]   lock_id_q, lock_id_d;
`endif

  logic             slot_free;
  logic [nReq-1:0]  masked, req, pick, grant, grant_shl, mask_next;
  logic             accept;
  logic [IdW-1:0]   win_id;
  logic [DataW-1:0] win_data;
  logic             win_last;

  always_comb begin
    slot_free = ~out_valid_q | out_ready;
    masked    = in_valid & mask_q;
    req       = (|masked) ? masked : in_valid;
    // Two's-complement trick isolates the lowest set request bit.
    pick      = req & (~req + nReq'(1));
`ifdef RR_ARB_MUX_LOCK_EN
    if (lock_q) pick = in_valid & (nReq'(1) << lock_id_q);
`endif
    grant     = (slot_free && !reset) ? pick : '0;
    accept    = |(in_valid & grant);

    win_id = '0;
    for (int i = 0; i < nReq; i++) begin
      if (grant[i]) win_id = IdW'(i);
    end
    win_data = in_data[win_id*DataW +: DataW];
    win_last = in_last[win_id];

    // All bits strictly above the winner; winner at the top wraps to zero.
    grant_shl = grant << 1;
    mask_next = ~(grant_shl - nReq'(1));

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    mask_d      = mask_q;
`ifdef RR_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_id_d    = win_id;
      out_last_d  = win_last;
`ifdef RR_ARB_MUX_LOCK_EN
      if (win_last) begin
        mask_d = mask_next;
        lock_d = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = win_id;
      end
`else
      mask_d = mask_next;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      mask_q      <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      mask_q      <= mask_d;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign in_ready  = grant;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - randomized and directed check of rr_arb_mux against a pointer-based model
// Model tracks "next preferred channel" as an integer and scans circularly from it.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_last;

  rr_arb_mux #(.nReq(N), .DataW(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending requests per channel.
  logic         pv[N];
  logic [W-1:0] pd[N];
  logic         pl[N];
  logic         hold_mode;

  // Reference model state.
  logic         m_valid, m_last, m_lock;
  logic [W-1:0] m_data;
  int           m_id, m_ptr, m_lock_id;
  int           last_id;
  logic         last_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    int w;
    w = -1;
`ifdef RR_ARB_MUX_LOCK_EN
    if (m_lock) return pv[m_lock_id] ? m_lock_id : -1;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (w < 0 && pv[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic step(input logic r, input logic ordy);
    int       w;
    logic     acc;
    logic [N-1:0] exp_rdy;
    @(negedge clock);
    reset     = r;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_valid[i]        = pv[i];
      in_data[i*W +: W]  = pd[i];
      in_last[i]         = pl[i];
    end
    #1;
    w   = pick_winner();
    acc = !r && (!m_valid || ordy) && (w >= 0);
    exp_rdy = acc ? (N'(1) << w) : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_id", 64'(out_id), 64'(m_id));
    chk("out_last", 64'(out_last), 64'(m_last));
    last_id    = int'(out_id);
    last_valid = out_valid;
    @(posedge clock);
    if (r) begin
      m_valid = 0; m_data = '0; m_id = 0; m_last = 0;
      m_ptr = 0; m_lock = 0; m_lock_id = 0;
    end else if (acc) begin
      m_valid = 1; m_data = pd[w]; m_id = w; m_last = pl[w];
`ifdef RR_ARB_MUX_LOCK_EN
      if (pl[w]) begin
        m_ptr = (w + 1) % N; m_lock = 0;
      end else begin
        m_lock = 1; m_lock_id = w;
      end
`else
      m_ptr = (w + 1) % N;
`endif
      if (!hold_mode) pv[w] = 0;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic set_chan(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      pv[i] = v[i];
      pd[i] = 32'h100 * (i + 1);
      pl[i] = 1'b1;
    end
  endtask

  initial begin
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    m_valid = 0; m_data = '0; m_id = 0; m_last = 0;
    m_ptr = 0; m_lock = 0; m_lock_id = 0;
    hold_mode = 1;
    set_chan(4'b0000);
    repeat (2) @(posedge clock);

    step(1, 0);
    step(1, 1);

    // All channels valid: strict rotation, no bubbles.
    set_chan(4'b1111);
    step(0, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, 1);
      chk("rot_valid", 64'(last_valid), 64'(1));
      chk("rot_id", 64'(last_id), 64'(exp_seq[k]));
    end

    // Odd channels only.
    step(1, 0);
    set_chan(4'b1010);
    step(0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1);
      chk("odd_id", 64'(last_id), 64'((k % 2 == 0) ? 1 : 3));
    end

    // Stall with ch2 beat held, then ch3 wins after release.
    step(1, 0);
    hold_mode = 0;
    set_chan(4'b0100);
    pd[2] = 32'hA5;
    step(0, 1);
    pv[0] = 1; pv[3] = 1;
    repeat (3) step(0, 0);
    chk("stall_data", 64'(out_data), 64'h A5);
    step(0, 1);
    step(0, 1);
    chk("after_stall_id", 64'(last_id), 64'(3));

    // Single requester ch3 wraps the pointer; ch0 wins next.
    step(1, 0);
    hold_mode = 1;
    set_chan(4'b1000);
    repeat (3) step(0, 1);
    pv[0] = 1;
    step(0, 1);
    step(0, 1);
    chk("wrap_id", 64'(last_id), 64'(0));

    // Reset mid-operation drops the beat and rewinds the pointer.
    set_chan(4'b0010);
    repeat (2) step(0, 0);
    step(1, 0);
    set_chan(4'b1111);
    step(0, 1);
    step(0, 1);
    chk("post_reset_id", 64'(last_id), 64'(0));

    // Random traffic with stable-until-ready requests.
    hold_mode = 0;
    set_chan(4'b0000);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 3 == 0)) begin
          pv[i] = 1;
          pd[i] = $urandom;
          pl[i] = ($urandom % 3 != 0);
        end
      end
      step(($urandom % 150) == 0, ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
